// File: rtl/dj8v_mem_arbiter.sv
// dj8v_mem_arbiter: shares the 8-bit multiplexed external memory bus between CPU and debug port.
// Build option: define DBG_PRIORITY_EN for fixed debug-port priority (default is round-robin).
module dj8v_mem_arbiter #(
  parameter int AW          = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [7:0]    dbg_wdata,
  output logic          dbg_ack,
  output logic [7:0]    rdata,
  output logic          busy,
  input  logic [7:0]    bus_in,
  output logic [7:0]    bus_out,
  output logic [7:0]    bus_oe,
  output logic          mem_ale_lo,
  output logic          mem_ale_hi,
  output logic          mem_we_n,
  output logic          mem_oe_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AL   = 3'd1;
  localparam logic [2:0] S_AH   = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          gnt_dbg_q, gnt_dbg_d;
  logic          pick_dbg;
  logic [15:0]   addr_ext;
`ifndef DBG_PRIORITY_EN
  logic          last_dbg_q, last_dbg_d;
`endif

  logic          cpu_ack_d, dbg_ack_d, busy_d;
  logic [7:0]    rdata_d, bus_out_d, bus_oe_d;
  logic          ale_lo_d, ale_hi_d, we_n_d, oe_n_d;

`ifdef DBG_PRIORITY_EN
  assign pick_dbg = dbg_req;
`else
  // Round-robin: on a tie, the requester that did not win last time goes first.
  assign pick_dbg = dbg_req && (!cpu_req || !last_dbg_q);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_dbg_d = gnt_dbg_q;
`ifndef DBG_PRIORITY_EN
    last_dbg_d = last_dbg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          gnt_dbg_d = pick_dbg;
          we_d      = pick_dbg ? dbg_we    : cpu_we;
          addr_d    = pick_dbg ? dbg_addr  : cpu_addr;
          wdata_d   = pick_dbg ? dbg_wdata : cpu_wdata;
`ifndef DBG_PRIORITY_EN
          last_dbg_d = pick_dbg;
`endif
          state_d   = S_AL;
        end
      end
      S_AL: state_d = S_AH;
      S_AH: begin
        state_d = S_DATA;
        cnt_d   = 3'(WAIT_CYCLES);
      end
      S_DATA: begin
        if (cnt_q == 3'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addr_ext = 16'(addr_d);

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  always_comb begin
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    rdata_d   = rdata;
    bus_out_d = 8'h00;
    bus_oe_d  = 8'h00;
    ale_lo_d  = 1'b0;
    ale_hi_d  = 1'b0;
    we_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    if (state_q == S_DATA && cnt_q == 3'd0 && !we_q) rdata_d = bus_in;
    case (state_d)
      S_AL: begin
        bus_oe_d  = 8'hFF;
        bus_out_d = addr_ext[7:0];
        ale_lo_d  = 1'b1;
      end
      S_AH: begin
        bus_oe_d  = 8'hFF;
        bus_out_d = addr_ext[15:8];
        ale_hi_d  = 1'b1;
      end
      S_DATA: begin
        if (we_d) begin
          bus_oe_d  = 8'hFF;
          bus_out_d = wdata_d;
          we_n_d    = 1'b0;
        end else begin
          oe_n_d    = 1'b0;
        end
      end
      S_DONE: begin
        cpu_ack_d = !gnt_dbg_d;
        dbg_ack_d = gnt_dbg_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      gnt_dbg_q  <= 1'b0;
`ifndef DBG_PRIORITY_EN
      last_dbg_q <= 1'b1;
`endif
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      busy       <= 1'b0;
      rdata      <= 8'h00;
      bus_out    <= 8'h00;
      bus_oe     <= 8'h00;
      mem_ale_lo <= 1'b0;
      mem_ale_hi <= 1'b0;
      mem_we_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_dbg_q  <= gnt_dbg_d;
`ifndef DBG_PRIORITY_EN
      last_dbg_q <= last_dbg_d;
`endif
      cpu_ack    <= cpu_ack_d;
      dbg_ack    <= dbg_ack_d;
      busy       <= busy_d;
      rdata      <= rdata_d;
      bus_out    <= bus_out_d;
      bus_oe     <= bus_oe_d;
      mem_ale_lo <= ale_lo_d;
      mem_ale_hi <= ale_hi_d;
      mem_we_n   <= we_n_d;
      mem_oe_n   <= oe_n_d;
    end
  end

endmodule

// File: tb/tb_dj8v_mem_arbiter.sv
// Directed bench for dj8v_mem_arbiter; acks are checked against a scoreboard of expected winners.
module tb_dj8v_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [11:0] cpu_addr = 0, dbg_addr = 0;
  logic [7:0]  cpu_wdata = 0, dbg_wdata = 0, bus_in = 0;
  logic        cpu_ack, dbg_ack, busy, mem_ale_lo, mem_ale_hi, mem_we_n, mem_oe_n;
  logic [7:0]  rdata, bus_out, bus_oe;

  logic        cpu_req0 = 0, cpu_we0 = 0, dbg_req0 = 0, dbg_we0 = 0;
  logic [11:0] cpu_addr0 = 0, dbg_addr0 = 0;
  logic [7:0]  cpu_wdata0 = 0, dbg_wdata0 = 0, bus_in0 = 0;
  logic        cpu_ack0, dbg_ack0, busy0, ale_lo0, ale_hi0, we_n0, oe_n0;
  logic [7:0]  rdata0, bus_out0, bus_oe0;

  int vecs = 0;
  int errs = 0;

`ifdef DBG_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct packed {
    logic       dbg;
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  wire [30:0] outs = {cpu_ack, dbg_ack, rdata, busy, bus_out, bus_oe,
                      mem_ale_lo, mem_ale_hi, mem_we_n, mem_oe_n};

  always #5 clk = ~clk;

  dj8v_mem_arbiter #(.AW(12), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .rdata(rdata), .busy(busy), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .mem_ale_lo(mem_ale_lo), .mem_ale_hi(mem_ale_hi), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n)
  );

  dj8v_mem_arbiter #(.AW(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0), .cpu_ack(cpu_ack0),
    .dbg_req(dbg_req0), .dbg_we(dbg_we0), .dbg_addr(dbg_addr0), .dbg_wdata(dbg_wdata0), .dbg_ack(dbg_ack0),
    .rdata(rdata0), .busy(busy0), .bus_in(bus_in0), .bus_out(bus_out0), .bus_oe(bus_oe0),
    .mem_ale_lo(ale_lo0), .mem_ale_hi(ale_hi0), .mem_we_n(we_n0), .mem_oe_n(oe_n0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dbg, input logic rd, input logic [7:0] d);
    sb.push_back(exp_t'{dbg, rd, d});
  endtask

  // Ack monitor: every ack must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (cpu_ack || dbg_ack)) begin
      chk("ack_onehot", {31'd0, cpu_ack & dbg_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_who", {30'd0, dbg_ack, cpu_ack}, mon_e.dbg ? 32'd2 : 32'd1);
        if (mon_e.rd) chk("ack_rdata", {24'd0, rdata}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vals", {1'b0, outs}, 32'h3);
    rst_n = 1'b1;

    // CPU write on the WAIT=1 unit, CPU write on the WAIT=0 unit in parallel
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'hA5C; cpu_wdata = 8'h3E;
    push(1'b0, 1'b0, 8'h00);
    cpu_req0 = 1; cpu_we0 = 1; cpu_addr0 = 12'h155; cpu_wdata0 = 8'hC3;
    tick();
    chk("w_c1_bus", {24'd0, bus_out}, 32'h5C);
    chk("w_c1_ale", {30'd0, mem_ale_lo, bus_oe == 8'hFF}, 32'h3);
    chk("w_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("w_c2_bus", {24'd0, bus_out}, 32'h0A);
    chk("w_c2_ale", {30'd0, mem_ale_hi, mem_ale_lo}, 32'h2);
    chk("w0_c2_bus", {24'd0, bus_out0}, 32'h01);
    tick();
    chk("w_c3_bus", {24'd0, bus_out}, 32'h3E);
    chk("w_c3_we", {30'd0, mem_we_n, bus_oe == 8'hFF}, 32'h1);
    chk("w0_c3_data", {23'd0, we_n0, bus_out0}, 32'h0C3);
    tick();
    chk("w_c4_data", {23'd0, mem_we_n, bus_out}, 32'h03E);
    chk("w0_c4_ack", {30'd0, cpu_ack0, we_n0}, 32'h3);
    chk("w0_c4_oe", {24'd0, bus_oe0}, 32'h00);
    cpu_req0 = 0;
    tick();
    chk("w_c5_ack", {30'd0, cpu_ack, dbg_ack}, 32'h2);
    chk("w_c5_idle_bus", {22'd0, mem_we_n, busy, bus_oe}, 32'h300);
    cpu_req = 0;
    tick();
    chk("w_c6_busy", {31'd0, busy}, 32'd0);

    // Debug read of 0x123 with 0x77 on the bus during DATA
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h123;
    push(1'b1, 1'b1, 8'h77);
    tick();
    chk("r_c1_bus", {24'd0, bus_out}, 32'h23);
    tick();
    chk("r_c2_bus", {24'd0, bus_out}, 32'h01);
    bus_in = 8'h77;
    tick();
    chk("r_c3_turn", {22'd0, mem_oe_n, mem_we_n, bus_oe}, 32'h100);
    tick();
    chk("r_c4_turn", {22'd0, mem_oe_n, mem_we_n, bus_oe}, 32'h100);
    tick();
    chk("r_c5_ack", {22'd0, dbg_ack, cpu_ack, rdata}, 32'h277);
    chk("r_c5_oe", {23'd0, mem_oe_n, bus_oe}, 32'h100);
    dbg_req = 0; bus_in = 8'h00;

    // Command change after grant must not disturb the transaction
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h2B7; cpu_wdata = 8'h44;
    push(1'b0, 1'b0, 8'h00);
    tick();
    chk("cc_c1_bus", {24'd0, bus_out}, 32'hB7);
    tick();
    chk("cc_c2_bus", {24'd0, bus_out}, 32'h02);
    cpu_addr = 12'h000; cpu_wdata = 8'h00; cpu_we = 0; cpu_req = 0;
    tick();
    chk("cc_c3_data", {23'd0, mem_we_n, bus_out}, 32'h044);
    tick();
    tick();
    chk("cc_c5_ack", {30'd0, cpu_ack, dbg_ack}, 32'h2);
    chk("cc_c5_rdata_hold", {24'd0, rdata}, 32'h77);

    // Reset during AH of a CPU write: no ack, then CPU wins the first tie
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h3C4; cpu_wdata = 8'h99;
    tick();
    tick();
    chk("ab_c2_ah", {31'd0, mem_ale_hi}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_reset_vals", {1'b0, outs}, 32'h3);
    cpu_wdata = 8'h11; cpu_addr = 12'h010;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h020; dbg_wdata = 8'h22;
    push(PRIO, 1'b0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ab_first_grant", {24'd0, bus_out}, PRIO ? 32'h20 : 32'h10);
    repeat (4) tick();
    chk("ab_ack", {30'd0, cpu_ack, dbg_ack}, PRIO ? 32'h1 : 32'h2);
    cpu_req = 0; dbg_req = 0;

    // Both requesters held from reset: grants alternate, acks every 6 cycles
    tick();
    rst_n = 1'b0;
    cpu_req = 1; cpu_we = 0; dbg_req = 1; dbg_we = 0; bus_in = 8'h5A;
    for (int k = 0; k < 4; k++) push(PRIO ? 1'b1 : logic'(k % 2), 1'b1, 8'h5A);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_ack", {30'd0, cpu_ack, dbg_ack}, PRIO ? 32'h1 : ((k % 2 == 0) ? 32'h2 : 32'h1));
      if (k < 3) repeat (6) tick();
    end
    cpu_req = 0; dbg_req = 0; bus_in = 8'h00;

    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
